// File: rtl/hqm_aw_async_data_resp.sv
// Purpose: destination-side responder of a toggle req/ack data crossing; captures src_data on each
//          synchronized request toggle, presents it with valid/ready, returns an ack toggle on accept.
// Latency: out_v rises SYNC_DEPTH+1 dst_clk edges after the request toggle is first sampled.
// Backpressure: out_v/out_data hold while out_ready=0; the ack is withheld until the consumer accepts.
//
// Ports:
//   dst_clk, dst_rst_n   destination clock, async active-low reset
//   src_req_tgl          request toggle from the source domain (asynchronous)
//   src_data[WIDTH]      source data, quasi-static from req toggle until the source sees the ack
//   dst_ack_tgl          registered ack toggle back to the source
//   out_v/out_ready      downstream valid/ready handshake, out_data stable while out_v=1
//   data_f[WIDTH]        last accepted data, held
//   busy                 request in flight
//   proto_err / err_clr  sticky protocol-violation flag and its clear
// Optional build macro HQM_AW_ASYNC_DATA_RESP_PARITY_EN adds src_par (even parity over src_data)
// and the sticky par_err output, also cleared by err_clr.
module hqm_aw_async_data_resp #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RST_DEFAULT = '0,
    parameter int                 SYNC_DEPTH  = 2     // legal 2..4
) (
    input  logic                  dst_clk,
    input  logic                  dst_rst_n,
    input  logic                  src_req_tgl,
    input  logic [WIDTH-1:0]      src_data,
`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
    input  logic                  src_par,
    output logic                  par_err,
`endif
    output logic                  dst_ack_tgl,
    output logic                  out_v,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [WIDTH-1:0]      data_f,
    output logic                  busy,
    output logic                  proto_err,
    input  logic                  err_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_DEPTH-1:0]  req_sync;
    logic                   req_s;
    logic                   req_prev;
    logic                   req_edge;
    // Holds a request edge that lands in the same cycle the current word is accepted,
    // so it is served on the following IDLE cycle instead of being lost.
    logic                   req_pend;
    logic                   req_pend_nxt;
    logic                   out_v_nxt;
    logic [WIDTH-1:0]       out_data_nxt;
    logic [WIDTH-1:0]       data_f_nxt;
    logic                   ack_nxt;
    logic                   proto_set;
    logic                   capture;

    // Request-toggle synchronizer; req_prev starts at 0, so a toggle held high across
    // reset is seen as exactly one request afterwards.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            req_sync <= '0;
            req_prev <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_DEPTH-2:0], src_req_tgl};
            req_prev <= req_s;
        end
    end

    assign req_s    = req_sync[SYNC_DEPTH-1];
    assign req_edge = req_s ^ req_prev;

    always_comb begin
        state_nxt    = state;
        out_v_nxt    = out_v;
        out_data_nxt = out_data;
        data_f_nxt   = data_f;
        ack_nxt      = dst_ack_tgl;
        req_pend_nxt = req_pend;
        proto_set    = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (req_edge || req_pend) begin
                    capture      = 1'b1;
                    out_data_nxt = src_data;
                    out_v_nxt    = 1'b1;
                    req_pend_nxt = 1'b0;
                    state_nxt    = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    data_f_nxt   = out_data;
                    ack_nxt      = ~dst_ack_tgl;
                    out_v_nxt    = 1'b0;
                    req_pend_nxt = req_edge;
                    state_nxt    = IDLE;
                end else if (req_edge) begin
                    // New request while the previous word is still unaccepted: the source
                    // broke the handshake. Flag it and drop the request (no ack).
                    proto_set = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                out_v_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            state       <= IDLE;
            out_v       <= 1'b0;
            out_data    <= '0;
            data_f      <= RST_DEFAULT;
            dst_ack_tgl <= 1'b0;
            req_pend    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_v       <= out_v_nxt;
            out_data    <= out_data_nxt;
            data_f      <= data_f_nxt;
            dst_ack_tgl <= ack_nxt;
            req_pend    <= req_pend_nxt;
            // set has priority over clear
            proto_err   <= proto_set | (proto_err & ~err_clr);
        end
    end

    assign busy = (state == VALID);

`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
    logic par_set;

    // Checked on the capturing edge so par_err rises together with out_v; the word is still
    // delivered and acked.
    assign par_set = capture & (^{src_data, src_par});

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_set | (par_err & ~err_clr);
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_hqm_aw_async_data_resp.sv
module tb_hqm_aw_async_data_resp;

    localparam int          WIDTH       = 32;
    localparam logic [31:0] RST_DEFAULT = 32'hA5A5_5A5A;
    localparam int          SYNC_DEPTH  = 2;
    localparam int          TIMEOUT     = 20;

    logic              dst_clk;
    logic              dst_rst_n;
    logic              src_req_tgl;
    logic [WIDTH-1:0]  src_data;
    logic              dst_ack_tgl;
    logic              out_v;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [WIDTH-1:0]  data_f;
    logic              busy;
    logic              proto_err;
    logic              err_clr;
`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
    logic              src_par;
    logic              par_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: words the source has launched but the consumer has not yet taken,
    // number of accepted words (ack level is its parity) and the last accepted word.
    logic [31:0] exp_q[$];
    int          ack_cnt;
    logic [31:0] last_acc;
    logic        par_flip;

    hqm_aw_async_data_resp #(
        .WIDTH       (WIDTH),
        .RST_DEFAULT (RST_DEFAULT),
        .SYNC_DEPTH  (SYNC_DEPTH)
    ) dut (
        .dst_clk     (dst_clk),
        .dst_rst_n   (dst_rst_n),
        .src_req_tgl (src_req_tgl),
        .src_data    (src_data),
`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
        .src_par     (src_par),
        .par_err     (par_err),
`endif
        .dst_ack_tgl (dst_ack_tgl),
        .out_v       (out_v),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .data_f      (data_f),
        .busy        (busy),
        .proto_err   (proto_err),
        .err_clr     (err_clr)
    );

    initial dst_clk = 1'b0;
    always #5 dst_clk = ~dst_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] d);
        src_data = d;
`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
        src_par  = (^d) ^ par_flip;
`endif
        exp_q.push_back(d);
    endtask

    // Waits for out_v, holds the consumer off for 'delay' cycles, then accepts and checks the ack.
    task automatic finish_request(input int delay);
        int          n;
        logic [31:0] exp_d;
        n = 0;
        out_ready = (delay == 0);
        do begin
            @(negedge dst_clk);
            n++;
        end while (!out_v && n < TIMEOUT);
        exp_d = exp_q.pop_front();
        check("out_v_latency", n, SYNC_DEPTH + 1);
        check("out_data", out_data, exp_d);
        check("busy_valid", {31'd0, busy}, 32'd1);
`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
        check("par_err", {31'd0, par_err}, {31'd0, par_flip});
`endif
        for (int i = 0; i < delay; i++) begin
            @(negedge dst_clk);
            check("hold_out_v", {31'd0, out_v}, 32'd1);
            check("hold_out_data", out_data, exp_d);
            check("hold_no_ack", {31'd0, dst_ack_tgl}, ack_cnt % 2);
            check("hold_data_f", data_f, last_acc);
        end
        out_ready = 1'b1;
        @(negedge dst_clk);
        ack_cnt++;
        last_acc = exp_d;
        check("ack_tgl", {31'd0, dst_ack_tgl}, ack_cnt % 2);
        check("out_v_fall", {31'd0, out_v}, 32'd0);
        check("data_f", data_f, last_acc);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("proto_err_clean", {31'd0, proto_err}, 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic do_request(input logic [31:0] d, input int delay);
        launch(d);
        src_req_tgl = ~src_req_tgl;
        finish_request(delay);
    endtask

    initial begin
        dst_rst_n   = 1'b0;
        src_req_tgl = 1'b0;
        src_data    = '0;
        out_ready   = 1'b0;
        err_clr     = 1'b0;
        par_flip    = 1'b0;
        ack_cnt     = 0;
        last_acc    = RST_DEFAULT;
`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
        src_par     = 1'b0;
`endif
        repeat (3) @(negedge dst_clk);
        check("rst_out_v", {31'd0, out_v}, 32'd0);
        check("rst_ack", {31'd0, dst_ack_tgl}, 32'd0);
        check("rst_data_f", data_f, RST_DEFAULT);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
        check("rst_par_err", {31'd0, par_err}, 32'd0);
`endif
        dst_rst_n = 1'b1;
        repeat (2) @(negedge dst_clk);

        // Single request, consumer always ready.
        do_request(32'hDEAD_BEEF, 0);
        // Consumer stalls 10 cycles.
        do_request($urandom, 10);
        // Four back-to-back requests, each launched once the ack is seen.
        for (int k = 1; k <= 4; k++) do_request(k, 0);
        // Randomized data and consumer stall lengths.
        for (int k = 0; k < 20; k++) do_request($urandom, $urandom_range(0, 4));

        // Protocol violation: second toggle while the first word is still pending.
        begin
            logic [31:0] a;
            int          n;
            a = $urandom;
            launch(a);
            out_ready   = 1'b0;
            src_req_tgl = ~src_req_tgl;
            n = 0;
            do begin
                @(negedge dst_clk);
                n++;
            end while (!out_v && n < TIMEOUT);
            check("perr_first_v", {31'd0, out_v}, 32'd1);
            src_req_tgl = ~src_req_tgl;
            repeat (4) @(negedge dst_clk);
            check("perr_set", {31'd0, proto_err}, 32'd1);
            check("perr_out_v", {31'd0, out_v}, 32'd1);
            check("perr_out_data", out_data, a);
            check("perr_no_ack", {31'd0, dst_ack_tgl}, ack_cnt % 2);
            out_ready = 1'b1;
            @(negedge dst_clk);
            ack_cnt++;
            last_acc = exp_q.pop_front();
            check("perr_ack", {31'd0, dst_ack_tgl}, ack_cnt % 2);
            check("perr_data_f", data_f, last_acc);
            for (int i = 0; i < 5; i++) begin
                @(negedge dst_clk);
                check("perr_no_second_v", {31'd0, out_v}, 32'd0);
                check("perr_no_second_ack", {31'd0, dst_ack_tgl}, ack_cnt % 2);
            end
            out_ready = 1'b0;
            check("perr_sticky", {31'd0, proto_err}, 32'd1);
            err_clr = 1'b1;
            @(negedge dst_clk);
            err_clr = 1'b0;
            check("perr_cleared", {31'd0, proto_err}, 32'd0);
        end

        // Normal operation resumes after the violation.
        do_request($urandom, 1);

`ifdef HQM_AW_ASYNC_DATA_RESP_PARITY_EN
        // Bad parity is flagged but the word is still delivered and acked.
        par_flip = 1'b1;
        do_request(32'h0000_0001, 0);
        check("par_err_sticky", {31'd0, par_err}, 32'd1);
        par_flip = 1'b0;
        err_clr = 1'b1;
        @(negedge dst_clk);
        err_clr = 1'b0;
        check("par_err_cleared", {31'd0, par_err}, 32'd0);
        do_request(32'h0000_0001, 0);
`endif

        // Reset with the request toggle held high: exactly one request afterwards.
        begin
            logic [31:0] d;
            d = $urandom;
            dst_rst_n = 1'b0;
            exp_q.delete();
            ack_cnt  = 0;
            last_acc = RST_DEFAULT;
            src_req_tgl = 1'b1;
            launch(d);
            @(negedge dst_clk);
            check("rst2_data_f", data_f, RST_DEFAULT);
            check("rst2_ack", {31'd0, dst_ack_tgl}, 32'd0);
            check("rst2_out_v", {31'd0, out_v}, 32'd0);
            dst_rst_n = 1'b1;
            finish_request(0);
            for (int i = 0; i < 5; i++) begin
                @(negedge dst_clk);
                check("rst2_single_v", {31'd0, out_v}, 32'd0);
                check("rst2_single_ack", {31'd0, dst_ack_tgl}, 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hqm_aw_async_data_resp.md
Name: hqm_AW_async_data_resp

Overview:
- Destination-side responder of a toggle req/ack data-crossing protocol. Lossless counterpart to the fire-and-forget pulse crossing.
- The source toggles src_req_tgl with src_data held stable. This block synchronizes the toggle, captures the data and presents it downstream with valid/ready.
- It toggles dst_ack_tgl back to the source only after the downstream consumer accepts, so no request is dropped.
- Used for dst-domain config/status registers that must not lose back-to-back writes.

Parameters:
- WIDTH, 32, data width.
- RST_DEFAULT, 0, reset value of held register data_f.
- SYNC_DEPTH, 2, flops in the req-toggle synchronizer (legal 2..4).

Ports:
- dst_clk  in  1  destination clock
- dst_rst_n  in  1  async active-low reset
- src_req_tgl  in  1  request toggle from source domain (asynchronous)
- src_data  in  WIDTH  source data; quasi-static from req toggle until ack toggle observed by source
- dst_ack_tgl  out  1  ack toggle returned to source domain (registered)
- out_v  out  1  captured data valid
- out_ready  in  1  downstream accept
- out_data  out  WIDTH  captured data, stable while out_v=1
- data_f  out  WIDTH  last accepted data, held
- busy  out  1  request in flight (state != IDLE)
- proto_err  out  1  sticky protocol-violation flag
- err_clr  in  1  clears proto_err

Behaviour:
- Clock dst_clk; reset dst_rst_n, asynchronous, active-low.
- Reset values:
  - sync chain, req_prev, dst_ack_tgl, out_v, busy, proto_err = 0.
  - out_data = 0; data_f = RST_DEFAULT; state = IDLE.
- Synchronizer and edge detect:
  - src_req_tgl passes through SYNC_DEPTH flops to give req_s.
  - req_prev <= req_s every cycle.
  - req_edge = req_s ^ req_prev; each toggle yields exactly one req_edge cycle.
- FSM (2 states):
  - IDLE: on req_edge, out_data <= src_data, out_v <= 1, go to VALID. Latency: out_v asserts 1 cycle after req_edge, i.e. SYNC_DEPTH+1 dst_clk edges after the toggle is sampled.
  - VALID: out_v=1 and out_data held. On out_v&&out_ready, at the same edge: data_f <= out_data, dst_ack_tgl <= ~dst_ack_tgl, out_v <= 0, go to IDLE.
- Ack timing and back-to-back requests:
  - Ack toggles exactly once per accepted request, never before acceptance.
  - A req_edge in the acceptance cycle is processed in the next IDLE cycle. This cannot occur under a legal protocol.
- Protocol error:
  - A req_edge while in VALID sets proto_err (sticky). The request is ignored and no ack is issued.
  - err_clr clears proto_err the next cycle; a simultaneous set wins.
- Reset mid-operation: a pending request is dropped and ack is not toggled. Source and dst resets are required to be applied together.
- Post-reset edge rule: req_prev resets to 0, so a src_req_tgl held at 1 across reset produces exactly one request after reset.
- busy = (state==VALID).
- No combinational paths from any input to any output.

Optional Feature:
- Macro: HQM_AW_ASYNC_DATA_RESP_PARITY_EN.
- When defined:
  - Adds input src_par (1b, even parity over src_data, same stability rules as src_data).
  - Adds output par_err (sticky, cleared by err_clr).
  - On capture, if ^{src_data,src_par}!=0, par_err sets the same cycle out_v rises. The data is still delivered and acked.
- When undefined: ports absent, no parity logic.

Test Plan:
- Reset with src_req_tgl=0 -> out_v=0, dst_ack_tgl=0, data_f=RST_DEFAULT, busy=0, proto_err=0.
- Toggle req 0->1 with src_data=0xDEADBEEF, out_ready=1 -> out_v high 1 cycle after req_edge with out_data=0xDEADBEEF; dst_ack_tgl 0->1 same edge out_v falls; data_f=0xDEADBEEF.
- out_ready=0 for 10 cycles after out_v -> out_v and out_data stable, no ack toggle; raise out_ready -> single ack toggle, data_f updated.
- Four back-to-back requests 0x1..0x4, each toggle issued only after the source sees ack -> four out_v pulses in order, four ack toggles, proto_err=0.
- Second toggle while out_ready=0 (VALID) -> proto_err=1, only one out_v/ack for first data; err_clr=1 -> proto_err=0 next cycle.
- Parity macro defined: src_data=0x00000001, src_par=0 -> par_err=1 when out_v rises, data still acked; with src_par=1 -> par_err stays 0.
